mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port, 1-cycle-read-latency work RAM between three requesters: CPU, GFX and DMA.
//   Sits directly in front of the memory block. Drives its address, write-data and write-enable ports and fans its read data back out.
//   Issues at most one access per cycle. GFX has fixed priority; CPU and DMA round-robin between themselves.
//   Bounded locked bursts are supported.
// PARAMETERS
//   BITS          16  data width
//   ADDRESS_BITS  15  word address width
//   MAX_BURST     8   max consecutive grants to one locked owner (>=1)
//   STARVE_MAX    4   consecutive denied cycles before a CPU/DMA request is starved (guard only)
// PORTS
//   CLK           in   1             system clock, all state on posedge
//   RSTb          in   1             asynchronous active-low reset
//   X_REQ         in   1             X in {CPU,GFX,DMA}: access request, held until granted
//   X_WR          in   1             1 = write, 0 = read
//   X_LOCK        in   1             keep ownership for next cycle if still requesting
//   X_ADDR        in   ADDRESS_BITS  word address
//   X_DIN         in   BITS          write data
//   X_GNT         out  1             access issued this cycle (combinational)
//   X_RVALID      out  1             read data for X valid on RDATA (registered)
//   RDATA         out  BITS          shared read-data bus (= MEM_DIN)
//   MEM_ADDRESS   out  ADDRESS_BITS  to memory ADDRESS
//   MEM_DOUT      out  BITS          to memory DATA_IN
//   MEM_WR        out  1             to memory WR
//   MEM_DIN       in   BITS          from memory DATA_OUT
// BEHAVIOUR
//   - Reset: all X_GNT=0, X_RVALID=0, MEM_WR=0, MEM_ADDRESS=0, MEM_DOUT=0.
//     Owner=NONE, RR pointer=CPU, burst count=0, starve counters=0.
//   - Ownership FSM states: IDLE, OWN_CPU, OWN_GFX, OWN_DMA. Entered when a grant is issued with X_LOCK=1.
//   - Per-cycle grant, evaluated in this order:
//     1) starved master (guard builds only);
//     2) locked owner with REQ=1 and burst count < MAX_BURST;
//     3) GFX;
//     4) RR pointer's master, else the other of CPU/DMA.
//   - Locked owner: drops REQ or LOCK -> IDLE and normal arbitration in that same cycle.
//     Burst count hits MAX_BURST -> FSM forced to IDLE for one arbitration.
//     The owner competes normally in that arbitration (GFX wins again if nothing is starved).
//   - Burst count: =1 on the entering grant, +1 per locked grant, cleared in IDLE.
//   - RR pointer: points to the other master after any CPU or DMA grant. Unchanged by GFX grants.
//   - Memory side: MEM_* driven combinationally from the granted port.
//     No grant -> MEM_WR=0, MEM_ADDRESS=0, MEM_DOUT=0.
//   - Read latency: grant at cycle T -> X_RVALID=1 at T+1 with RDATA=MEM_DIN.
//     Writes never raise RVALID. A write at T followed by a read of the same address at T+1 returns the new data.
//   - Exactly one X_GNT high at most; exactly one X_RVALID high at most.
//   - Reset mid-burst: everything clears immediately, asynchronously. An in-flight read's RVALID is lost.
// CONFIGURATION
//   MEM_ARB_STARVE_GUARD_EN defined:
//     - One saturating counter each for CPU and DMA. Increments when REQ=1 and not granted.
//     - Clears on grant or REQ=0.
//     - At STARVE_MAX the master wins the next cycle, preempting GFX and breaking any lock (FSM -> IDLE).
//     - Both starved -> CPU first.
//   Not defined: counters absent; pure priority; a continuous GFX stream may starve CPU/DMA indefinitely.
// TESTING
//   1. RAM[0x0010]=0xBEEF; CPU read 0x0010 -> CPU_GNT same cycle, next cycle CPU_RVALID=1, RDATA=0xBEEF.
//   2. GFX+CPU REQ held continuously, no lock:
//      guard on, STARVE_MAX=4 -> 4 GFX grants, then 1 CPU grant, repeating;
//      guard off -> CPU_GNT never asserts.
//   3. CPU+DMA REQ held, GFX idle, after reset -> grants alternate CPU, DMA, CPU, DMA ...
//   4. DMA LOCK=1, 10 writes, CPU REQ held, MAX_BURST=8 -> 8 consecutive DMA_GNT, then CPU_GNT, then DMA resumes.
//   5. RSTb low during a GFX locked burst -> all GNT/RVALID and MEM_WR low without a clock edge.
//      After release, CPU+DMA request -> CPU granted first.
//   6. CPU writes 0x1234 to 0x7FFF at T, reads 0x7FFF at T+1 -> RDATA=0x1234 with CPU_RVALID at T+2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-way work-RAM arbiter: GFX fixed priority, CPU/DMA round-robin, bounded locked bursts.
// Optional starvation guard for CPU/DMA is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arbiter #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 15,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_MAX   = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,

    input  logic                    CPU_REQ,
    input  logic                    CPU_WR,
    input  logic                    CPU_LOCK,
    input  logic [ADDRESS_BITS-1:0] CPU_ADDR,
    input  logic [BITS-1:0]         CPU_DIN,
    output logic                    CPU_GNT,
    output logic                    CPU_RVALID,

    input  logic                    GFX_REQ,
    input  logic                    GFX_WR,
    input  logic                    GFX_LOCK,
    input  logic [ADDRESS_BITS-1:0] GFX_ADDR,
    input  logic [BITS-1:0]         GFX_DIN,
    output logic                    GFX_GNT,
    output logic                    GFX_RVALID,

    input  logic                    DMA_REQ,
    input  logic                    DMA_WR,
    input  logic                    DMA_LOCK,
    input  logic [ADDRESS_BITS-1:0] DMA_ADDR,
    input  logic [BITS-1:0]         DMA_DIN,
    output logic                    DMA_GNT,
    output logic                    DMA_RVALID,

    output logic [BITS-1:0]         RDATA,
    output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
    output logic [BITS-1:0]         MEM_DOUT,
    output logic                    MEM_WR,
    input  logic [BITS-1:0]         MEM_DIN
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_CPU,
        OWN_GFX,
        OWN_DMA
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BCW-1:0] burst_cnt;
    logic [BCW-1:0] burst_nxt;
    logic           rr_dma;
    logic           gnt_cpu;
    logic           gnt_gfx;
    logic           gnt_dma;
    logic           locked_gnt;
    logic           burst_ok;
    logic           own_cpu;
    logic           own_gfx;
    logic           own_dma;
    logic           starved_cpu;
    logic           starved_dma;
    logic           cpu_rv;
    logic           gfx_rv;
    logic           dma_rv;

    // Ownership only holds while the owner keeps REQ and LOCK and has burst budget left
    assign burst_ok = burst_cnt < BCW'(MAX_BURST);
    assign own_cpu  = (state == OWN_CPU) && CPU_REQ && CPU_LOCK && burst_ok;
    assign own_gfx  = (state == OWN_GFX) && GFX_REQ && GFX_LOCK && burst_ok;
    assign own_dma  = (state == OWN_DMA) && DMA_REQ && DMA_LOCK && burst_ok;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_cpu;
    logic [SCW-1:0] starve_dma;

    assign starved_cpu = CPU_REQ && (starve_cpu == SCW'(STARVE_MAX));
    assign starved_dma = DMA_REQ && (starve_dma == SCW'(STARVE_MAX));

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            starve_cpu <= '0;
            starve_dma <= '0;
        end else begin
            if (!CPU_REQ || gnt_cpu)
                starve_cpu <= '0;
            else if (starve_cpu != SCW'(STARVE_MAX))
                starve_cpu <= starve_cpu + 1'b1;

            if (!DMA_REQ || gnt_dma)
                starve_dma <= '0;
            else if (starve_dma != SCW'(STARVE_MAX))
                starve_dma <= starve_dma + 1'b1;
        end
    end
`else
    assign starved_cpu = 1'b0;
    assign starved_dma = 1'b0;
`endif

    // Grants are gated by reset so they drop without waiting for a clock edge
    always_comb begin
        gnt_cpu    = 1'b0;
        gnt_gfx    = 1'b0;
        gnt_dma    = 1'b0;
        locked_gnt = 1'b0;
        if (!RSTb) begin
            locked_gnt = 1'b0;
        end else if (starved_cpu) begin
            gnt_cpu = 1'b1;
        end else if (starved_dma) begin
            gnt_dma = 1'b1;
        end else if (own_cpu) begin
            gnt_cpu    = 1'b1;
            locked_gnt = 1'b1;
        end else if (own_gfx) begin
            gnt_gfx    = 1'b1;
            locked_gnt = 1'b1;
        end else if (own_dma) begin
            gnt_dma    = 1'b1;
            locked_gnt = 1'b1;
        end else if (GFX_REQ) begin
            gnt_gfx = 1'b1;
        end else if (!rr_dma) begin
            if (CPU_REQ)
                gnt_cpu = 1'b1;
            else if (DMA_REQ)
                gnt_dma = 1'b1;
        end else begin
            if (DMA_REQ)
                gnt_dma = 1'b1;
            else if (CPU_REQ)
                gnt_cpu = 1'b1;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        burst_nxt = '0;
        if (gnt_cpu && CPU_LOCK) begin
            state_nxt = OWN_CPU;
            burst_nxt = locked_gnt ? burst_cnt + 1'b1 : BCW'(1);
        end else if (gnt_gfx && GFX_LOCK) begin
            state_nxt = OWN_GFX;
            burst_nxt = locked_gnt ? burst_cnt + 1'b1 : BCW'(1);
        end else if (gnt_dma && DMA_LOCK) begin
            state_nxt = OWN_DMA;
            burst_nxt = locked_gnt ? burst_cnt + 1'b1 : BCW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_dma    <= 1'b0;
            cpu_rv    <= 1'b0;
            gfx_rv    <= 1'b0;
            dma_rv    <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (gnt_cpu)
                rr_dma <= 1'b1;
            else if (gnt_dma)
                rr_dma <= 1'b0;
            cpu_rv <= gnt_cpu & ~CPU_WR;
            gfx_rv <= gnt_gfx & ~GFX_WR;
            dma_rv <= gnt_dma & ~DMA_WR;
        end
    end

    always_comb begin
        MEM_ADDRESS = '0;
        MEM_DOUT    = '0;
        MEM_WR      = 1'b0;
        unique case (1'b1)
            gnt_cpu: begin
                MEM_ADDRESS = CPU_ADDR;
                MEM_DOUT    = CPU_DIN;
                MEM_WR      = CPU_WR;
            end
            gnt_gfx: begin
                MEM_ADDRESS = GFX_ADDR;
                MEM_DOUT    = GFX_DIN;
                MEM_WR      = GFX_WR;
            end
            gnt_dma: begin
                MEM_ADDRESS = DMA_ADDR;
                MEM_DOUT    = DMA_DIN;
                MEM_WR      = DMA_WR;
            end
            default: begin
                MEM_WR = 1'b0;
            end
        endcase
    end

    assign CPU_GNT    = gnt_cpu;
    assign GFX_GNT    = gnt_gfx;
    assign DMA_GNT    = gnt_dma;
    assign CPU_RVALID = cpu_rv;
    assign GFX_RVALID = gfx_rv;
    assign DMA_RVALID = dma_rv;
    assign RDATA      = MEM_DIN;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency RAM model.
// Expectations follow MEM_ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;

    logic        cpu_req = 0, cpu_wr = 0, cpu_lock = 0;
    logic [14:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic        gfx_req = 0, gfx_wr = 0, gfx_lock = 0;
    logic [14:0] gfx_addr = '0;
    logic [15:0] gfx_din = '0;
    logic        gfx_gnt, gfx_rvalid;
    logic        dma_req = 0, dma_wr = 0, dma_lock = 0;
    logic [14:0] dma_addr = '0;
    logic [15:0] dma_din = '0;
    logic        dma_gnt, dma_rvalid;

    logic [15:0] rdata;
    logic [14:0] mem_address;
    logic [15:0] mem_dout;
    logic        mem_wr;
    logic [15:0] mem_din;

    logic        ld_en = 1'b0;
    logic [14:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] ram [0:32767];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en)
            ram[ld_addr] <= ld_data;
        else if (mem_wr)
            ram[mem_address] <= mem_dout;
        mem_din <= ram[mem_address];
    end

    mem_arbiter dut (
        .CLK(clk), .RSTb(rstb),
        .CPU_REQ(cpu_req), .CPU_WR(cpu_wr), .CPU_LOCK(cpu_lock),
        .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din),
        .CPU_GNT(cpu_gnt), .CPU_RVALID(cpu_rvalid),
        .GFX_REQ(gfx_req), .GFX_WR(gfx_wr), .GFX_LOCK(gfx_lock),
        .GFX_ADDR(gfx_addr), .GFX_DIN(gfx_din),
        .GFX_GNT(gfx_gnt), .GFX_RVALID(gfx_rvalid),
        .DMA_REQ(dma_req), .DMA_WR(dma_wr), .DMA_LOCK(dma_lock),
        .DMA_ADDR(dma_addr), .DMA_DIN(dma_din),
        .DMA_GNT(dma_gnt), .DMA_RVALID(dma_rvalid),
        .RDATA(rdata), .MEM_ADDRESS(mem_address), .MEM_DOUT(mem_dout),
        .MEM_WR(mem_wr), .MEM_DIN(mem_din)
    );

    wire [2:0] gvec = {cpu_gnt, gfx_gnt, dma_gnt};
    wire [2:0] rvec = {cpu_rvalid, gfx_rvalid, dma_rvalid};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        cpu_req = 0; cpu_lock = 0; cpu_wr = 0;
        gfx_req = 0; gfx_lock = 0; gfx_wr = 0;
        dma_req = 0; dma_lock = 0; dma_wr = 0;
    endtask

    task automatic do_reset();
        drop_all();
        rstb = 1'b0;
        next_cycle();
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        cpu_req = 1; dma_req = 1; gfx_req = 1;
        @(negedge clk);
        checks++;
        if (gvec !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt: got %b expected 000", gvec);
        end
        checks++;
        if (rvec !== 3'b000) begin
            errors++;
            $display("FAIL reset_rvalid: got %b expected 000", rvec);
        end
        checks++;
        if ({mem_wr, mem_address, mem_dout} !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: got wr=%b a=%h d=%h expected 0/0/0",
                     mem_wr, mem_address, mem_dout);
        end
        drop_all();
        next_cycle();
        rstb = 1'b1;
    endtask

    task automatic test_cpu_read();
        do_reset();
        ld_en = 1; ld_addr = 15'h0010; ld_data = 16'hBEEF;
        next_cycle();
        ld_en = 0;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 15'h0010;
        @(negedge clk);
        checks++;
        if (gvec !== 3'b100) begin
            errors++;
            $display("FAIL read_gnt: got %b expected 100", gvec);
        end
        checks++;
        if (mem_address !== 15'h0010 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL read_mem: got a=%h wr=%b expected a=0010 wr=0",
                     mem_address, mem_wr);
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if (rvec !== 3'b100) begin
            errors++;
            $display("FAIL read_rvalid: got %b expected 100", rvec);
        end
        checks++;
        if (rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_data: got %h expected beef", rdata);
        end
    endtask

    task automatic test_gfx_priority();
        logic [2:0] exp;
        do_reset();
        gfx_req = 1; gfx_addr = 15'h0100;
        cpu_req = 1; cpu_addr = 15'h0200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp = (i % 5 == 4) ? 3'b100 : 3'b010;
`else
            exp = 3'b010;
`endif
            checks++;
            if (gvec !== exp) begin
                errors++;
                $display("FAIL prio_cycle%0d: got %b expected %b", i, gvec, exp);
            end
            next_cycle();
        end
        drop_all();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        do_reset();
        cpu_req = 1; dma_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = (i % 2 == 0) ? 3'b100 : 3'b001;
            checks++;
            if (gvec !== exp) begin
                errors++;
                $display("FAIL rr_cycle%0d: got %b expected %b", i, gvec, exp);
            end
            next_cycle();
        end
        drop_all();
    endtask

    task automatic test_burst();
        logic [2:0] exp_seq [12];
        logic [2:0] g;
        int         done;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
                    3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                    3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b000};
`endif
        done = 0;
        do_reset();
        dma_req = 1; dma_lock = 1; dma_wr = 1;
        dma_addr = 15'h0200; dma_din = 16'hD000;
        cpu_addr = 15'h0010; cpu_wr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            g = gvec;
            checks++;
            if (g !== exp_seq[i]) begin
                errors++;
                $display("FAIL burst_cycle%0d: got %b expected %b", i, g, exp_seq[i]);
            end
            next_cycle();
            if (g[0]) begin
                done++;
                if (done == 10) begin
                    dma_req = 0;
                end else begin
                    dma_addr = dma_addr + 15'd1;
                    dma_din  = dma_din + 16'd1;
                end
            end
            if (g[2])
                cpu_req = 0;
            if (i == 0)
                cpu_req = 1;
        end
        checks++;
        if (ram[15'h0209] !== 16'hD009) begin
            errors++;
            $display("FAIL burst_last_write: got %h expected d009", ram[15'h0209]);
        end
        drop_all();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        cpu_req = 1; cpu_addr = 15'h0010;
        next_cycle();
        cpu_req = 0;
        gfx_req = 1; gfx_lock = 1; gfx_wr = 0; gfx_addr = 15'h0020;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (gvec !== 3'b010 || rvec !== 3'b010) begin
            errors++;
            $display("FAIL burst_pre_reset: got gnt=%b rv=%b expected 010/010", gvec, rvec);
        end
        #2;
        rstb = 1'b0;
        #1;
        checks++;
        if (gvec !== 3'b000 || rvec !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b rv=%b expected 000/000", gvec, rvec);
        end
        checks++;
        if (mem_wr !== 1'b0 || mem_address !== 15'h0) begin
            errors++;
            $display("FAIL async_reset_mem: got wr=%b a=%h expected 0/0000",
                     mem_wr, mem_address);
        end
        drop_all();
        cpu_req = 1; dma_req = 1;
        next_cycle();
        rstb = 1'b1;
        @(negedge clk);
        checks++;
        if (gvec !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_rr: got %b expected 100", gvec);
        end
        next_cycle();
        drop_all();
    endtask

    task automatic test_write_read();
        do_reset();
        cpu_req = 1; cpu_wr = 1; cpu_addr = 15'h7FFF; cpu_din = 16'h1234;
        @(negedge clk);
        checks++;
        if (gvec !== 3'b100 || mem_wr !== 1'b1 || mem_dout !== 16'h1234
            || mem_address !== 15'h7FFF) begin
            errors++;
            $display("FAIL wr_issue: got gnt=%b wr=%b a=%h d=%h expected 100/1/7fff/1234",
                     gvec, mem_wr, mem_address, mem_dout);
        end
        next_cycle();
        cpu_wr = 0;
        @(negedge clk);
        checks++;
        if (rvec !== 3'b000) begin
            errors++;
            $display("FAIL wr_no_rvalid: got %b expected 000", rvec);
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if (rvec !== 3'b100 || rdata !== 16'h1234) begin
            errors++;
            $display("FAIL rd_after_wr: got rv=%b d=%h expected 100/1234", rvec, rdata);
        end
        checks++;
        if ({mem_wr, mem_address, mem_dout} !== 32'h0 || gvec !== 3'b000) begin
            errors++;
            $display("FAIL idle_mem: got gnt=%b wr=%b a=%h d=%h expected all 0",
                     gvec, mem_wr, mem_address, mem_dout);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_gfx_priority();
        test_round_robin();
        test_burst();
        test_reset_mid_burst();
        test_write_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
